// File: rtl/status_value_reader_pkg.sv
// Shared types and constants for the status value reader and its skid buffer.
package status_value_reader_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(SKID_DEPTH);

endpackage

// File: rtl/status_value_reader_if.sv
// Vector-side and downstream-side signals of the reader; master is the reader itself.
interface status_value_reader_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             vec_valid_i;
  logic [WIDTH-1:0] vec_value_i;
  logic             vec_pull_o;
  logic             hold_i;
  logic             flush_i;
  logic [WIDTH-1:0] data_o;
  logic             data_valid_o;
  logic             data_ready_i;
  logic             flush_done_o;
  logic             busy_o;
  logic [CNT_W-1:0] deliv_cnt_o;
  logic [CNT_W-1:0] drop_cnt_o;

  modport master (
    input  vec_valid_i, vec_value_i, hold_i, flush_i, data_ready_i,
    output vec_pull_o, data_o, data_valid_o, flush_done_o, busy_o,
           deliv_cnt_o, drop_cnt_o
  );

  modport slave (
    output vec_valid_i, vec_value_i, hold_i, flush_i, data_ready_i,
    input  vec_pull_o, data_o, data_valid_o, flush_done_o, busy_o,
           deliv_cnt_o, drop_cnt_o
  );
endinterface

// File: rtl/status_value_skid.sv
// Two-entry registered FIFO; head is a register that keeps its last value when empty.
module status_value_skid
  import status_value_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [OCC_W-1:0] occ,
  output logic             valid
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [OCC_W-1:0] occ_q;
  logic             pop_ok;
  logic             wr;

  assign pop_ok = pop && (occ_q != '0);
  assign wr     = push && ((occ_q != OCC_FULL) || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else if (clear) begin
      occ_q <= '0;
    end else begin
      if (pop_ok && occ_q == OCC_FULL) head_q <= tail_q;
      if (wr) begin
        // New data lands in head only if head is empty or being vacated with nothing behind it.
        if (occ_q == '0 || (pop_ok && occ_q == OCC_ONE)) head_q <= din;
        else                                             tail_q <= din;
      end
      occ_q <= occ_q + OCC_W'(wr) - OCC_W'(pop_ok);
    end
  end

  assign head  = head_q;
  assign occ   = occ_q;
  assign valid = (occ_q != '0);

endmodule

// File: rtl/status_value_reader.sv
// Drains the status vector head into a 2-entry skid buffer for a valid/ready consumer,
// with hold, flush-and-discard, and delivered/dropped counters.
module status_value_reader
  import status_value_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic                   clk_i,
  input logic                   rsn_i,
  status_value_reader_if.master bus
);

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] deliv_q;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W:0]   drop_sum;

  logic             in_run;
  logic             pull, push, pop, clear;
  logic [WIDTH-1:0] skid_head;
  logic [OCC_W-1:0] occ;
  logic             skid_valid;

  assign in_run = (state_q == ST_RUN);

  // Reset gates pull so the vector is never drained while the reader is held in reset.
  assign pull  = rsn_i && bus.vec_valid_i &&
                 (!in_run || (!bus.hold_i && (occ != OCC_FULL) && !bus.flush_i));
  assign push  = pull && in_run;
  assign clear = in_run && bus.flush_i;
  assign pop   = bus.data_valid_o && bus.data_ready_i && !bus.flush_i;

  status_value_skid #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk_i),
    .rst_n (rsn_i),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (bus.vec_value_i),
    .head  (skid_head),
    .occ   (occ),
    .valid (skid_valid)
  );

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
      deliv_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      deliv_q <= deliv_q + CNT_W'(pop);
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_RUN:   if (bus.flush_i) state_d = ST_FLUSH;
      ST_FLUSH: if (!bus.vec_valid_i) begin
        state_d = ST_RUN;
        done_d  = 1'b1;
      end
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    drop_sum = {1'b0, drop_q};
    if (clear)                drop_sum = drop_sum + (CNT_W+1)'(occ);
    else if (pull && !in_run) drop_sum = drop_sum + (CNT_W+1)'(1);
    drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  assign bus.vec_pull_o   = pull;
  assign bus.data_o       = skid_head;
  assign bus.data_valid_o = in_run && skid_valid;
  assign bus.flush_done_o = done_q;
  assign bus.busy_o       = !in_run || skid_valid;
  assign bus.deliv_cnt_o  = deliv_q;
  assign bus.drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_status_value_reader.sv
// Directed and random bench for status_value_reader with a queue-based reference model.
module tb_status_value_reader;

  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rsn = 1'b0;
  always #5 clk = ~clk;

  status_value_reader_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  status_value_reader #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rsn_i (rsn),
    .bus   (bus.master)
  );

  logic [W-1:0] vq[$];
  logic [W-1:0] sq[$];
  bit           m_flush;
  bit           m_done;
  int           m_deliv;
  int           m_drop;
  logic [W-1:0] m_data;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    sq.delete();
    m_flush = 0;
    m_done  = 0;
    m_deliv = 0;
    m_drop  = 0;
    m_data  = '0;
  endtask

  task automatic chk_zero_outputs();
    chk("rst_pull",  32'(bus.vec_pull_o),   0);
    chk("rst_dv",    32'(bus.data_valid_o), 0);
    chk("rst_data",  32'(bus.data_o),       0);
    chk("rst_done",  32'(bus.flush_done_o), 0);
    chk("rst_busy",  32'(bus.busy_o),       0);
    chk("rst_deliv", 32'(bus.deliv_cnt_o),  0);
    chk("rst_drop",  32'(bus.drop_cnt_o),   0);
  endtask

  // Called at a falling edge with hold/flush/ready already driven.
  task automatic step();
    bit e_pull, e_dv, e_pop, vld, nxt_done;
    vld = (vq.size() != 0);
    bus.vec_valid_i = vld;
    bus.vec_value_i = vld ? vq[0] : W'($urandom);
    #1;
    e_dv   = !m_flush && (sq.size() != 0);
    e_pull = vld && (m_flush || (!bus.hold_i && sq.size() < 2 && !bus.flush_i));
    e_pop  = e_dv && bus.data_ready_i && !bus.flush_i;
    chk("pull",  32'(bus.vec_pull_o),   32'(e_pull));
    chk("dvalid",32'(bus.data_valid_o), 32'(e_dv));
    chk("data",  32'(bus.data_o),       32'(m_data));
    chk("done",  32'(bus.flush_done_o), 32'(m_done));
    chk("busy",  32'(bus.busy_o),       32'(m_flush || sq.size() != 0));
    chk("deliv", 32'(bus.deliv_cnt_o),  32'(m_deliv));
    chk("drop",  32'(bus.drop_cnt_o),   32'(m_drop));
    @(posedge clk);
    nxt_done = m_flush && !vld;
    if (!m_flush && bus.flush_i) begin
      m_drop = sat(m_drop + sq.size());
      sq.delete();
      m_flush = 1;
    end else if (m_flush) begin
      if (e_pull) m_drop = sat(m_drop + 1);
      if (!vld) m_flush = 0;
    end else begin
      if (e_pop) begin
        void'(sq.pop_front());
        m_deliv = (m_deliv + 1) % (CMAX + 1);
      end
      if (e_pull) sq.push_back(vq[0]);
    end
    if (e_pull) void'(vq.pop_front());
    m_done = nxt_done;
    if (sq.size() != 0) m_data = sq[0];
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input bit hold, input bit flush, input bit ready);
    bus.hold_i       = hold;
    bus.flush_i      = flush;
    bus.data_ready_i = ready;
  endtask

  initial begin
    drive(0, 0, 0);
    bus.vec_valid_i = 1'b1;
    bus.vec_value_i = 8'hA5;
    model_reset();
    #1;
    chk_zero_outputs();
    @(negedge clk);
    rsn = 1'b1;

    // Full-throughput drain
    vq = '{8'h11, 8'h22, 8'h33};
    drive(0, 0, 1);
    run(5);
    chk("deliv_after_3", 32'(bus.deliv_cnt_o), 3);

    // Backpressure: two pulls, then drain in order
    vq = '{8'h11, 8'h22, 8'h33};
    drive(0, 0, 0);
    run(4);
    chk("bp_vec_left", vq.size(), 1);
    drive(0, 0, 1);
    run(5);
    chk("deliv_after_6", 32'(bus.deliv_cnt_o), 6);

    // Hold stops pulls but not pops
    vq = '{8'h44, 8'h55, 8'h66};
    drive(0, 0, 0);
    run(1);
    drive(1, 0, 1);
    run(3);
    chk("hold_vec_left", vq.size(), 2);
    drive(0, 0, 1);
    run(5);

    // Flush with occ=2 and five entries left in the vector
    for (int i = 0; i < 7; i++) vq.push_back(W'(8'h70 + i));
    drive(0, 0, 0);
    run(3);
    drive(0, 1, 0);
    run(1);
    drive(0, 0, 0);
    run(7);
    chk("drop_after_flush", 32'(bus.drop_cnt_o), 7);

    // Drop counter saturation
    for (int i = 0; i < 10; i++) vq.push_back(W'(8'h80 + i));
    run(3);
    drive(0, 1, 0);
    run(1);
    drive(0, 0, 0);
    run(12);
    chk("drop_saturated", 32'(bus.drop_cnt_o), CMAX);

    // Delivered counter wrap after 17 pops in total
    for (int i = 0; i < 8; i++) vq.push_back(W'(8'h90 + i));
    drive(0, 0, 1);
    run(12);
    chk("deliv_wrap", 32'(bus.deliv_cnt_o), 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (!m_flush && ($urandom % 3 == 0) && vq.size() < 8) vq.push_back(W'($urandom));
      drive(($urandom % 4) == 0, ($urandom % 25) == 0, ($urandom % 3) != 0);
      step();
    end
    drive(0, 0, 1);
    run(20);

    // Asynchronous reset mid-stream with occ=2
    vq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    drive(0, 0, 0);
    run(3);
    rsn = 1'b0;
    #1;
    chk_zero_outputs();
    @(posedge clk);
    @(negedge clk);
    rsn = 1'b1;
    model_reset();
    chk("rst_vec_kept", vq.size(), 2);
    drive(0, 0, 1);
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
